// File: rtl/coffee_vend_ctrl_if.sv
// rtl/coffee_vend_ctrl_if.sv - coin, selection, dispense and change handshake bundle
interface coffee_vend_ctrl_if #(
   parameter int unsigned VALUE_W = 8,
   parameter int unsigned SEL_W   = 2
);
   logic               coin_valid;
   logic [VALUE_W-1:0] coin_value;
   logic               coin_reject;
   logic               sel_valid;
   logic [SEL_W-1:0]   sel_idx;
   logic               dispense_valid;
   logic [SEL_W-1:0]   dispense_idx;
   logic               dispense_ready;
   logic               change_valid;
   logic [VALUE_W-1:0] change_value;
   logic               change_ready;

   modport master (
      output coin_valid, coin_value, sel_valid, sel_idx, dispense_ready, change_ready,
      input  coin_reject, dispense_valid, dispense_idx, change_valid, change_value
   );

   modport slave (
      input  coin_valid, coin_value, sel_valid, sel_idx, dispense_ready, change_ready,
      output coin_reject, dispense_valid, dispense_idx, change_valid, change_value
   );
endinterface

// File: rtl/coffee_vend_ctrl.sv
// rtl/coffee_vend_ctrl.sv - coin credit, product selection, dispense and change sequencing
// Optional inactivity timeout enabled by defining VEND_TIMEOUT_EN.
module coffee_vend_ctrl #(
   parameter int unsigned VALUE_W     = 8,
   parameter int unsigned N_PRODUCTS  = 4,
   parameter int unsigned SEL_W       = (N_PRODUCTS > 1) ? $clog2(N_PRODUCTS) : 1,
   parameter int unsigned TIMEOUT_CYC = 1000
) (
   input  logic                          clk,
   input  logic                          rst,
   coffee_vend_ctrl_if.slave             bus,
   input  logic [N_PRODUCTS*VALUE_W-1:0] price_table,
   input  logic                          cancel,
   output logic [VALUE_W-1:0]            credit,
   output logic                          LED_yellow,
   output logic                          LED_green
`ifdef VEND_TIMEOUT_EN
   ,
   output logic                          timeout_evt
`endif
);
   typedef enum logic [1:0] {IDLE, COLLECT, DISPENSE, CHANGE} state_t;

   state_t             state_q, state_d;
   logic [VALUE_W-1:0] credit_q, credit_d;
   logic [SEL_W-1:0]   sel_q, sel_d;
   logic               sel_locked_q, sel_locked_d;
   logic               cmp_q, cmp_d;
   logic               coin_reject_q, coin_reject_d;

   logic [VALUE_W-1:0] price_sel;
   logic [VALUE_W:0]   coin_sum;
   logic               sel_ok, coin_acc, sel_acc, cancel_eff, tmo_fire;

   always_comb begin
      price_sel = '0;
      for (int unsigned i = 0; i < N_PRODUCTS; i++)
         if (sel_q == SEL_W'(i)) price_sel = price_table[i*VALUE_W +: VALUE_W];
   end

   assign coin_sum = {1'b0, credit_q} + {1'b0, bus.coin_value};
   assign sel_ok   = 32'(bus.sel_idx) < N_PRODUCTS;

`ifdef VEND_TIMEOUT_EN
   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic             timeout_evt_q;

   assign tmo_fire    = (state_q == COLLECT) && (tmo_q == TMO_W'(TIMEOUT_CYC));
   assign timeout_evt = timeout_evt_q;
`else
   logic tmo_unused;
   assign tmo_unused = (TIMEOUT_CYC == 0);
   assign tmo_fire   = 1'b0;
`endif

   assign cancel_eff = cancel | tmo_fire;

   always_comb begin
      state_d       = state_q;
      credit_d      = credit_q;
      sel_d         = sel_q;
      sel_locked_d  = sel_locked_q;
      coin_reject_d = 1'b0;
      coin_acc      = 1'b0;
      sel_acc       = 1'b0;
      case (state_q)
         IDLE, COLLECT: begin
            if ((state_q == COLLECT) && cancel_eff) begin
               coin_reject_d = bus.coin_valid;
               sel_locked_d  = 1'b0;
               state_d       = (credit_q != '0) ? CHANGE : IDLE;
            end else begin
               if (bus.coin_valid) begin
                  if (coin_sum[VALUE_W]) begin
                     coin_reject_d = 1'b1;
                  end else begin
                     credit_d = coin_sum[VALUE_W-1:0];
                     coin_acc = 1'b1;
                  end
               end
               if (bus.sel_valid && sel_ok) begin
                  sel_d        = bus.sel_idx;
                  sel_locked_d = 1'b1;
                  sel_acc      = 1'b1;
               end
               // A fresh selection invalidates the registered compare, so hold off one round.
               if (state_q == IDLE) begin
                  if (coin_acc || sel_acc) state_d = COLLECT;
               end else if (cmp_q && !sel_acc) begin
                  state_d = DISPENSE;
               end
            end
         end
         DISPENSE: begin
            coin_reject_d = bus.coin_valid;
            if (bus.dispense_ready) begin
               credit_d     = credit_q - price_sel;
               sel_locked_d = 1'b0;
               state_d      = (credit_q != price_sel) ? CHANGE : IDLE;
            end
         end
         CHANGE: begin
            coin_reject_d = bus.coin_valid;
            if (bus.change_ready) begin
               credit_d = '0;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      cmp_d = sel_locked_q && !sel_acc && (credit_q >= price_sel);
`ifdef VEND_TIMEOUT_EN
      tmo_d = (state_d != COLLECT || coin_acc || sel_acc) ? '0 : tmo_q + 1'b1;
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         credit_q      <= '0;
         sel_q         <= '0;
         sel_locked_q  <= 1'b0;
         cmp_q         <= 1'b0;
         coin_reject_q <= 1'b0;
`ifdef VEND_TIMEOUT_EN
         tmo_q         <= '0;
         timeout_evt_q <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         credit_q      <= credit_d;
         sel_q         <= sel_d;
         sel_locked_q  <= sel_locked_d;
         cmp_q         <= cmp_d;
         coin_reject_q <= coin_reject_d;
`ifdef VEND_TIMEOUT_EN
         tmo_q         <= tmo_d;
         timeout_evt_q <= tmo_fire;
`endif
      end
   end

   assign bus.coin_reject    = coin_reject_q;
   assign bus.dispense_valid = (state_q == DISPENSE);
   assign bus.dispense_idx   = sel_q;
   assign bus.change_valid   = (state_q == CHANGE);
   assign bus.change_value   = (state_q == CHANGE) ? credit_q : '0;
   assign credit             = credit_q;
   assign LED_yellow         = (state_q == COLLECT);
   assign LED_green          = (state_q == DISPENSE);
endmodule
